// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: byte-enable generation,
// misalignment detection and load-lane extraction with sign/zero extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Little-endian lane select, then extend unless the unsigned variant is requested.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            SZ_WORD: res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner shared by the memory read path and the
// store-buffer forwarding path.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] data
);

    assign data = extract_load(word, size, off, uns);

endmodule

// File: rtl/lsu_store_buf.sv
// Load/store unit with a one-entry posted store buffer in front of dmem.
// Define LSU_STORE_FWD_EN to forward fully covered loads from the buffered store.
module lsu_store_buf
    import lsu_pkg::*;
#(
    parameter int AW          = 12,
    parameter bit ZERO_ON_ERR = 1'b1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          buf_empty,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic [3:0]    mem_be,
    output logic          mem_wren,
    input  logic [31:0]   mem_dout
);

    logic          buf_valid_r;
    logic [AW-3:0] buf_addr_r;
    logic [31:0]   buf_data_r;
    logic [3:0]    buf_be_r;
    logic [1:0]    buf_off_r;
    logic          rsp_valid_r;
    logic          rsp_err_r;
    logic [31:0]   rsp_rdata_r;

    logic [1:0]    off_s;
    logic [AW-3:0] req_word_s;
    logic          misal_s;
    logic [3:0]    need_be_s;
    logic          ld_s;
    logic          st_s;
    logic          fwd_hit_s;
    logic          stall_s;
    logic          drain_s;
    logic          ld_acc_s;
    logic [31:0]   load_word_s;
    logic [31:0]   ld_data_s;

    assign off_s      = req_addr[1:0];
    assign req_word_s = req_addr[AW-1:2];
    assign misal_s    = is_misaligned(req_size, off_s);
    assign need_be_s  = gen_be(req_size, off_s);
    assign ld_s       = req_valid & ~req_we & ~misal_s;
    assign st_s       = req_valid &  req_we & ~misal_s;

`ifdef LSU_STORE_FWD_EN
    assign fwd_hit_s = ld_s & buf_valid_r & (buf_addr_r == req_word_s)
                     & ((need_be_s & ~buf_be_r) == 4'b0000);
`else
    assign fwd_hit_s = 1'b0;
`endif

    // A valid entry owns the memory port unless the load is served from it;
    // any other load waits one cycle so a write never shares a read cycle.
    assign stall_s     = ld_s & buf_valid_r & ~fwd_hit_s;
    assign drain_s     = buf_valid_r & ~fwd_hit_s;
    assign ld_acc_s    = ld_s & ~stall_s;
    assign load_word_s = fwd_hit_s ? buf_data_r : mem_dout;

    lsu_load_align u_align (
        .word (load_word_s),
        .size (req_size),
        .off  (off_s),
        .uns  (req_unsigned),
        .data (ld_data_s)
    );

    // Memory port steering between buffer drain and load read.
    always_comb begin
        req_ready = ~stall_s;
        mem_wren  = 1'b0;
        mem_addr  = req_word_s;
        mem_be    = need_be_s;
        mem_din   = buf_data_r >> {buf_off_r, 3'b000};
        if (drain_s) begin
            mem_wren = 1'b1;
            mem_addr = buf_addr_r;
            mem_be   = buf_be_r;
        end else begin
            mem_wren = 1'b0;
        end
    end

    // Store buffer entry: filled on store accept, cleared by its drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= '0;
            buf_data_r  <= 32'h0000_0000;
            buf_be_r    <= 4'b0000;
            buf_off_r   <= 2'b00;
        end else if (st_s) begin
            buf_valid_r <= 1'b1;
            buf_addr_r  <= req_word_s;
            buf_data_r  <= req_wdata << {off_s, 3'b000};
            buf_be_r    <= need_be_s;
            buf_off_r   <= off_s;
        end else if (drain_s) begin
            buf_valid_r <= 1'b0;
        end
    end

    // Registered response: load data or misalignment error one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= ld_acc_s | (req_valid & misal_s);
            rsp_err_r   <= req_valid & misal_s;
            if (ld_acc_s) begin
                rsp_rdata_r <= ld_data_s;
            end else if (req_valid & misal_s & ~req_we & ZERO_ON_ERR) begin
                rsp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign buf_empty = ~buf_valid_r;

endmodule

// File: tb/tb_lsu_store_buf.sv
// Self-checking bench for lsu_store_buf: dmem model, response scoreboard and
// per-scenario tasks; expectations follow LSU_STORE_FWD_EN when defined.
module tb_lsu_store_buf;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        buf_empty;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_be;
    logic        mem_wren;
    logic [31:0] mem_dout;
    logic        mem_init = 1'b1;

    logic [31:0] mem [0:1023];

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    lsu_store_buf dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .buf_empty(buf_empty),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
        .mem_wren(mem_wren), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];

    // dmem model: value in low bits of mem_din is placed into the enabled lanes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[8]  <= 32'h80F1_7F02;
            mem[16] <= 32'h5A5A_5A5A;
        end else if (mem_wren) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_din[7:0];
            end
            if (mem_be == 4'b1100) mem[mem_addr][31:16] <= mem_din[15:0];
            if (mem_be == 4'b0011) mem[mem_addr][15:0]  <= mem_din[15:0];
            if (mem_be == 4'b1111) mem[mem_addr]        <= mem_din;
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected got data %h err %b, expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_err !== e.err || (e.chk && rsp_rdata !== e.data)) begin
                    fails++;
                    $display("FAIL rsp_data got data %h err %b, expected data %h err %b",
                             rsp_rdata, rsp_err, e.data, e.err);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_rsp, input logic exp_err, input logic exp_chk,
                         input logic [31:0] exp_data, output int stalls,
                         output logic w0, output logic [3:0] be0,
                         output logic [9:0] a0, output logic [31:0] d0);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        stalls = 0;
        #1;
        w0 = mem_wren; be0 = mem_be; a0 = mem_addr; d0 = mem_din;
        while (!req_ready && stalls < 4) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout req_ready stayed %b, expected 1", req_ready);
        end else if (exp_rsp) begin
            sb.push_back('{err: exp_err, chk: exp_chk, data: exp_data});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_init = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (buf_empty !== 1'b1) begin fails++; $display("FAIL reset_buf_empty got %b expected 1", buf_empty); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b expected 0", rsp_err); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h expected 0", rsp_rdata); end
        tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL reset_mem_wren got %b expected 0", mem_wren); end
        @(negedge clk);
        rst_n = 1'b1; mem_init = 1'b0;
    endtask

    task automatic test_store_load();
        int st; logic w0; logic [3:0] be0; logic [9:0] a0; logic [31:0] d0;
        idle(2);
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, st, w0, be0, a0, d0);
        tests++; if (st !== 0) begin fails++; $display("FAIL sw_stall got %0d expected 0", st); end
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, st, w0, be0, a0, d0);
`ifdef LSU_STORE_FWD_EN
        tests++; if (st !== 0 || w0 !== 1'b0) begin fails++; $display("FAIL lw_fwd got stall %0d wren %b expected 0 0", st, w0); end
        idle(1); #1;
        tests++; if (buf_empty !== 1'b0) begin fails++; $display("FAIL lw_fwd_kept got buf_empty %b expected 0", buf_empty); end
`else
        tests++; if (st !== 1) begin fails++; $display("FAIL lw_stall got %0d expected 1", st); end
        tests++; if (w0 !== 1'b1 || be0 !== 4'b1111 || a0 !== 10'd4 || d0 !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL lw_drain got wren %b be %b addr %0d din %h expected 1 1111 4 deadbeef", w0, be0, a0, d0);
        end
        idle(1); #1;
        tests++; if (buf_empty !== 1'b1) begin fails++; $display("FAIL lw_drained got buf_empty %b expected 1", buf_empty); end
`endif
        idle(2);
    endtask

    task automatic test_extract();
        int st; logic w0; logic [3:0] be0; logic [9:0] a0; logic [31:0] d0;
        logic [1:0]  sz [4]  = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
        logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4]  = '{32'h23, 32'h23, 32'h22, 32'h20};
        logic [31:0] ex [4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_7F02};
        idle(2);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0, 1'b1, 1'b0, 1'b1, ex[i], st, w0, be0, a0, d0);
            tests++; if (st !== 0 || w0 !== 1'b0) begin fails++; $display("FAIL extract_%0d got stall %0d wren %b expected 0 0", i, st, w0); end
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        int st; logic w0; logic [3:0] be0; logic [9:0] a0; logic [31:0] d0;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h0000_00AB, 1'b0, 1'b0, 1'b0, 32'h0, st, w0, be0, a0, d0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h36, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0, st, w0, be0, a0, d0);
        tests++; if (st !== 0 || w0 !== 1'b1 || be0 !== 4'b0010 || a0 !== 10'h0C || d0[7:0] !== 8'hAB) begin
            fails++; $display("FAIL sb_drain got stall %0d wren %b be %b addr %h din %h expected 0 1 0010 00c xxxxxxab", st, w0, be0, a0, d0);
        end
        @(negedge clk); req_valid = 1'b0; #1;
        tests++; if (mem_wren !== 1'b1 || mem_be !== 4'b1100 || mem_addr !== 10'h0D || mem_din[15:0] !== 16'h1234) begin
            fails++; $display("FAIL sh_drain got wren %b be %b addr %h din %h expected 1 1100 00d xxxx1234", mem_wren, mem_be, mem_addr, mem_din);
        end
        @(negedge clk); #1;
        tests++; if (mem[12] !== 32'h0000_AB00 || mem[13] !== 32'h1234_0000 || buf_empty !== 1'b1) begin
            fails++; $display("FAIL b2b_mem got %h %h empty %b expected 0000ab00 12340000 1", mem[12], mem[13], buf_empty);
        end
    endtask

    task automatic test_misaligned();
        int st; logic w0; logic [3:0] be0; logic [9:0] a0; logic [31:0] d0;
        idle(2);
        issue(1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, st, w0, be0, a0, d0);
        tests++; if (st !== 0 || w0 !== 1'b0) begin fails++; $display("FAIL mis_lw got stall %0d wren %b expected 0 0", st, w0); end
        issue(1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, st, w0, be0, a0, d0);
        tests++; if (st !== 0 || w0 !== 1'b0) begin fails++; $display("FAIL mis_lh got stall %0d wren %b expected 0 0", st, w0); end
        issue(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0, st, w0, be0, a0, d0);
        tests++; if (st !== 0 || w0 !== 1'b0) begin fails++; $display("FAIL mis_ill got stall %0d wren %b expected 0 0", st, w0); end
        idle(1); #1;
        tests++; if (buf_empty !== 1'b1 || mem_wren !== 1'b0) begin fails++; $display("FAIL mis_buf got empty %b wren %b expected 1 0", buf_empty, mem_wren); end
        idle(1); #1;
        tests++; if (mem[16] !== 32'h5A5A_5A5A) begin fails++; $display("FAIL mis_mem got %h expected 5a5a5a5a", mem[16]); end
    endtask

    task automatic test_forward();
        int st; logic w0; logic [3:0] be0; logic [9:0] a0; logic [31:0] d0;
        issue(1'b1, SZ_WORD, 1'b0, 32'h50, 32'h1122_8344, 1'b0, 1'b0, 1'b0, 32'h0, st, w0, be0, a0, d0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h51, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF83, st, w0, be0, a0, d0);
        idle(1); #1;
`ifdef LSU_STORE_FWD_EN
        tests++; if (st !== 0 || w0 !== 1'b0 || buf_empty !== 1'b0) begin
            fails++; $display("FAIL fwd_lb got stall %0d wren %b empty %b expected 0 0 0", st, w0, buf_empty);
        end
`else
        tests++; if (st !== 1 || w0 !== 1'b1 || buf_empty !== 1'b1) begin
            fails++; $display("FAIL stall_lb got stall %0d wren %b empty %b expected 1 1 1", st, w0, buf_empty);
        end
`endif
        idle(2);
    endtask

    task automatic test_reset_mid();
        int st; logic w0; logic [3:0] be0; logic [9:0] a0; logic [31:0] d0;
        issue(1'b1, SZ_WORD, 1'b0, 32'h60, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'h0, st, w0, be0, a0, d0);
        @(negedge clk);
        req_valid = 1'b0; rst_n = 1'b0;
        #1;
        tests++; if (buf_empty !== 1'b1 || mem_wren !== 1'b0) begin fails++; $display("FAIL rstmid_now got empty %b wren %b expected 1 0", buf_empty, mem_wren); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL rstmid_wren_%0d got %b expected 0", i, mem_wren); end
        end
        tests++; if (mem[24] !== 32'h0) begin fails++; $display("FAIL rstmid_mem got %h expected 0", mem[24]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_extract();
        test_back_to_back();
        test_misaligned();
        test_forward();
        test_reset_mid();
        idle(2);
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_drained got %0d pending expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_store_buf.md
Name: lsu_store_buf

Overview:
- Load/store unit between the core's memory-access stage and the data memory (dmem).
- Turns byte/half/word requests into dmem's 10-bit word address, 4-bit byte-enable and data; extracts and sign/zero-extends load data; flags misaligned accesses.
- Contains a one-entry posted store buffer so a store retires in its accept cycle and drains to dmem on a later cycle.
- dmem has one shared address port: reads are combinational, writes happen on posedge when wren=1.

Parameters:
- AW, 12, byte-address width seen by dmem (word address = req_addr[AW-1:2]).
- ZERO_ON_ERR, 1, when 1 a misaligned load returns rsp_rdata=0; when 0 rsp_rdata holds its previous value.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
- req_unsigned  in  1  loads: zero-extend (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store value, right-justified
- rsp_valid  out  1  one-cycle pulse: load data or error ready
- rsp_rdata  out  32  extended load data
- rsp_err  out  1  misaligned/illegal access, valid with rsp_valid
- buf_empty  out  1  store buffer empty (used for fence/halt)
- mem_addr  out  10  dmem word address
- mem_din  out  32  dmem write data; value in low bits (byte [7:0], half [15:0])
- mem_be  out  4  byte enable; bit k = byte offset k, lane [8k+7:8k]
- mem_wren  out  1  dmem write enable
- mem_dout  in  32  dmem combinational read data

Behaviour:
- Reset: async on rst_n low. Buffer invalid, buf_empty=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wren=0.
- Little-endian lanes:
  - byte: offset o gives be=1<<o.
  - half: offset 0 gives be=0011; offset 2 gives be=1100.
  - word: be=1111.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11):
  - accepted with req_ready=1; no buffer or memory effect.
  - next cycle: rsp_valid=1 and rsp_err=1, for both loads and stores.
- Buffer entry: word address, positioned lane data (internal), be.
- Drain: when the entry is valid and no load reads memory this cycle.
  - mem_addr=entry addr, mem_be=entry be, mem_wren=1, mem_din=entry data shifted down to the low bits.
  - Entry clears at that posedge.
- Store accept: req_ready=1 always.
  - If the entry is valid, it drains this cycle and the new store loads the entry at the same posedge.
  - No response for a good store.
- Load, buffer empty: req_ready=1; mem_addr=req_addr word address, mem_wren=0.
  - Extraction: lane selected by offset, extended per req_unsigned; registered.
  - rsp_valid=1 the next cycle (latency 1).
- Load, buffer valid, no forward hit: req_ready=0; entry drains; load is accepted the following cycle.
- Back-to-back loads: rsp_valid may stay high on consecutive cycles.
- mem_wren must never be 1 in a cycle where mem_addr serves a load read.
- Reset mid-drain: the pending store is lost; no partial write (wren is combinational from the valid flag).

Optional Feature:
- LSU_STORE_FWD_EN, when defined:
  - Load to the same word, whose needed bytes are all covered by entry be: req_ready=1, data taken from the entry, entry kept, no drain that cycle.
  - Partial overlap or different word: stall-and-drain as above.
- When undefined: any load with a valid entry stalls one cycle for drain.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - functions for be generation, misalignment check and load extraction/extension.
- Sub-module lsu_load_align (combinational extract + sign/zero-extend) is natural.
  - Also used by the forwarding path.

Test Plan:
- sw 0xDEADBEEF @0x10, next cycle lw @0x10:
  - without LSU_STORE_FWD_EN: 1-cycle stall, write be=1111 addr=4, then rsp_rdata=0xDEADBEEF.
  - with LSU_STORE_FWD_EN: no stall, same data.
- Memory word 0x80F17F02 @0x20:
  - lb @0x23 returns 0xFFFFFF80.
  - lbu @0x23 returns 0x00000080.
  - lh @0x22 returns 0xFFFF80F1.
  - lhu @0x20 returns 0x00007F02.
- sb 0xAB @0x31 then sh 0x1234 @0x36 back-to-back:
  - first drains mem_be=0010, mem_din[7:0]=0xAB, while the second enters the buffer; it later drains be=1100, mem_din[15:0]=0x1234.
- lw @0x42, lh @0x41, size=11: each gives rsp_valid=1 and rsp_err=1 the next cycle; no mem_wren; buffer untouched.
- sw @0x50 followed by lb @0x51 with LSU_STORE_FWD_EN: forwarded byte = data[15:8] sign-extended; entry still valid (buf_empty=0).
- Assert rst_n=0 while the entry is valid: buf_empty=1 immediately; no mem_wren after release; memory unchanged.
